// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with a valid/ready load handshake and a one-cycle done pulse.
module piso_tx #(
  parameter int WIDTH      = 24,
  parameter int BIT_CYCLES = 1,
  parameter bit LSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             ser_o,
  output logic             frame_o,
  output logic             done_o
);
  localparam int CW = $clog2(BIT_CYCLES) + 1;
  localparam int BW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             last_cyc, last_bit;
  assign last_cyc = cyc_q == CW'(BIT_CYCLES - 1);
  assign last_bit = bit_q == BW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: if (valid_i) begin
        state_d = SHIFT;
        sh_d    = data_i;
        cyc_d   = '0;
        bit_d   = '0;
      end
      SHIFT: if (last_cyc) begin
        cyc_d   = '0;
        sh_d    = LSB_FIRST ? sh_q >> 1 : sh_q << 1;
        bit_d   = last_bit ? '0 : bit_q + 1'b1;
        state_d = last_bit ? DONE : SHIFT;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
    end
  end
  // ready is gated by rst_n so it drops for the whole time reset is held
  assign ready_o = (state_q == IDLE) && rst_n;
  assign frame_o = state_q == SHIFT;
  assign done_o  = state_q == DONE;
  assign ser_o   = frame_o ? (LSB_FIRST ? sh_q[0] : sh_q[WIDTH-1]) : IDLE_LEVEL;
endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 24: number of bits per serialized word (legal 2..64).
REQ-002 Parameter BIT_CYCLES, default 1: clock cycles each bit is held on ser_o (legal 1..256).
REQ-003 Parameter LSB_FIRST, default 0: 0 shifts MSB first, 1 shifts LSB first.
REQ-004 Parameter IDLE_LEVEL, default 0: ser_o level when not shifting.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  reset; one clock; asynchronous, active-low.
REQ-007 data_i  input  WIDTH  parallel word to transmit.
REQ-008 valid_i  input  1  data_i is valid this cycle.
REQ-009 ready_o  output  1  block can accept a word this cycle.
REQ-010 ser_o  output  1  serial data out.
REQ-011 frame_o  output  1  high while ser_o carries word bits.
REQ-012 done_o  output  1  one-cycle pulse after the last bit period.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 IDLE: ready_o=1, frame_o=0, done_o=0, ser_o=IDLE_LEVEL.
REQ-015 Handshake SHALL occur on a rising edge where valid_i=1 and ready_o=1; data_i is captured into an internal WIDTH-bit shift register on that edge; IDLE->SHIFT.
REQ-016 valid_i while ready_o=0 SHALL be ignored; no queueing; data_i changes after capture SHALL NOT affect output.
REQ-017 SHIFT: ready_o=0, frame_o=1, done_o=0; ser_o = register MSB (LSB_FIRST=0) or LSB (LSB_FIRST=1), driven from a register, no combinational path from data_i.
REQ-018 First bit SHALL appear on ser_o in the cycle immediately after the handshake edge (latency 1).
REQ-019 Each bit SHALL be held exactly BIT_CYCLES cycles, counted by a cycle counter of width clog2(BIT_CYCLES)+1 that wraps to 0 at BIT_CYCLES-1.
REQ-020 A bit counter SHALL count 0..WIDTH-1; on the last cycle of bit WIDTH-1, SHIFT->DONE.
REQ-021 SHIFT SHALL last exactly WIDTH*BIT_CYCLES cycles.
REQ-022 DONE: lasts exactly one cycle; done_o=1, frame_o=0, ready_o=0, ser_o=IDLE_LEVEL; DONE->IDLE unconditionally.
REQ-023 Back-to-back: minimum spacing between handshakes SHALL be WIDTH*BIT_CYCLES+2 cycles; inter-word gap on ser_o is 2 cycles at IDLE_LEVEL.
REQ-024 BIT_CYCLES=1 SHALL shift one bit per clock with no idle cycles inside a frame.
REQ-025 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-026 reset low SHALL immediately (asynchronously) force IDLE, shift register=0, counters=0, ready_o=0 while asserted, frame_o=0, done_o=0, ser_o=IDLE_LEVEL.
REQ-027 Reset asserted mid-frame SHALL abort the word with no done_o pulse; the word is lost.
REQ-028 After reset deasserts, ready_o SHALL be 1 from the first rising edge onward; a handshake on that edge is accepted.

Verification
REQ-029 WIDTH=8, BIT_CYCLES=2, LSB_FIRST=0: accept 0xA5 -> ser_o = 1,0,1,0,0,1,0,1 each 2 cycles, frame_o high 16 cycles, done_o high on cycle 17 after handshake, ready_o high on cycle 18.
REQ-030 WIDTH=8, BIT_CYCLES=1, LSB_FIRST=1: accept 0x01 then hold valid_i=1 with 0xFF -> ser_o = 1,0,0,0,0,0,0,0; second word accepted exactly 10 cycles after first, ser_o = eight 1s.
REQ-031 valid_i pulsed with 0x3C during SHIFT of 0xC3 -> ignored, output stays 0xC3 pattern, no extra frame.
REQ-032 Reset asserted at bit 4 of 0xF0 (WIDTH=8) -> ser_o=IDLE_LEVEL and frame_o=0 immediately, no done_o; next accepted 0x0F transmits correctly.
REQ-033 IDLE_LEVEL=1, WIDTH=24, BIT_CYCLES=3: accept 0x000001 -> ser_o=1 before frame, 23 zeros then a 1 each 3 cycles, frame 72 cycles, ser_o=1 after.
REQ-034 Randomized data at WIDTH=24 compared against a reference model for bit order, per-bit hold length and done_o timing over 1000 words.
